// File: rtl/stereo_i2s_tx_pkg.sv
// rtl/stereo_i2s_tx_pkg.sv - shared widths, defaults and frame packing for the I2S transmitter
package stereo_i2s_tx_pkg;
  localparam int SAMPLE_W        = 16;
  localparam int FRAME_BITS      = 32;
  localparam int CNT_W           = 5;
  localparam int CLK_DIV_DEFAULT = 4;
  localparam int DIV_W           = 8;
  localparam int UCNT_W          = 8;

  function automatic logic [FRAME_BITS-1:0] pack_frame(input logic [SAMPLE_W-1:0] left,
                                                        input logic [SAMPLE_W-1:0] right);
    return {left, right};
  endfunction
endpackage

// File: rtl/i2s_clock_gen.sv
// rtl/i2s_clock_gen.sv - BCLK divider with a one-clk strobe in the cycle BCLK falls
module i2s_clock_gen
  import stereo_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic bclk,
  output logic fall_tick
);
  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             term;

  assign term = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    div_d  = term ? '0 : div_q + DIV_W'(1);
    bclk_d = term ? ~bclk_q : bclk_q;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk      = bclk_q;
  assign fall_tick = term & bclk_q;
endmodule

// File: rtl/stereo_i2s_tx.sv
// rtl/stereo_i2s_tx.sv - stereo I2S transmitter with one-pair holding register and underrun repeat
module stereo_i2s_tx
  import stereo_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                underrun,
  output logic [UCNT_W-1:0]   underrun_count
);
  logic                  fall_tick;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  logic                  full_q, full_d;
  logic                  ready_q;
  logic                  underrun_q, underrun_d;
  logic [UCNT_W-1:0]     ucnt_q, ucnt_d;
  logic                  accept;

  i2s_clock_gen #(.CLK_DIV(CLK_DIV)) u_clock_gen (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .bclk      (i2s_bclk),
    .fall_tick (fall_tick)
  );

  assign accept = sample_valid & ready_q;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    full_d     = full_q;
    underrun_d = 1'b0;
    ucnt_d     = ucnt_q;
    if (fall_tick) begin
      bit_cnt_d = bit_cnt_q + CNT_W'(1);
      // The shift continues through bit_cnt 0 so the last R bit lands one BCLK after LRCLK falls.
      if (bit_cnt_q == '0) begin
        if (full_q) begin
          shift_d = hold_q;
          frame_d = hold_q;
          full_d  = 1'b0;
        end else begin
          shift_d    = frame_q;
          underrun_d = 1'b1;
          if (ucnt_q != '1) ucnt_d = ucnt_q + UCNT_W'(1);
        end
      end else begin
        shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
      end
    end
    // Accept only happens while empty, so it can never collide with a load from full.
    if (accept) begin
      hold_d = pack_frame(sample_l, sample_r);
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      ready_q    <= ~full_d;
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign sample_ready   = ready_q;
  assign i2s_lrclk      = bit_cnt_q[CNT_W-1];
  assign i2s_sdata      = shift_q[FRAME_BITS-1];
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;
endmodule

// File: tb/tb_stereo_i2s_tx.sv
// tb/tb_stereo_i2s_tx.sv - scoreboard bench for stereo_i2s_tx against a frame-level reference model
module tb_stereo_i2s_tx;
  localparam int HALF  = 4;
  localparam int BPER  = 2 * HALF;
  localparam int FPER  = 32 * BPER;
  localparam int RST_T = 9 * FPER + 20 * BPER + HALF + 1;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] sample_l, sample_r;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata, underrun;
  logic [7:0]  underrun_count;

  stereo_i2s_tx #(.CLK_DIV(HALF)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .sample_l       (sample_l),
    .sample_r       (sample_r),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata),
    .underrun       (underrun),
    .underrun_count (underrun_count)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: time since reset release, one-pair holding slot, last sent frame.
  int          t;
  logic        full_m, ready_m, und_m;
  logic [31:0] hold_m, prev_m;
  int          cnt_m;
  logic [31:0] exp_q[$];

  int          mode;
  int          push_edge;
  logic [15:0] push_l, push_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    full_m = 1'b0; ready_m = 1'b0; und_m = 1'b0;
    hold_m = '0; prev_m = '0; cnt_m = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic        acc_now;
    logic [31:0] f;
    acc_now = sample_valid && ready_m;
    und_m = 1'b0;
    if (t % FPER == BPER) begin
      if (full_m) begin
        f = hold_m;
        full_m = 1'b0;
      end else begin
        f = prev_m;
        und_m = 1'b1;
        if (cnt_m < 255) cnt_m++;
      end
      prev_m = f;
      exp_q.push_back(f);
    end
    if (acc_now) begin
      full_m = 1'b1;
      hold_m = {sample_l, sample_r};
    end
    ready_m = !full_m;
  endtask

  task automatic check_cycle();
    chk("bclk",  32'(i2s_bclk),  32'((t / HALF) % 2));
    chk("lrclk", 32'(i2s_lrclk), 32'(((t / BPER) % 32) >= 16));
    chk("ready", 32'(sample_ready), 32'(ready_m));
    chk("underrun", 32'(underrun), 32'(und_m));
    chk("underrun_count", 32'(underrun_count), 32'(cnt_m));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bclk"},  32'(i2s_bclk), 0);
    chk({tag, "_lrclk"}, 32'(i2s_lrclk), 0);
    chk({tag, "_sdata"}, 32'(i2s_sdata), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
    chk({tag, "_count"}, 32'(underrun_count), 0);
    chk({tag, "_ready"}, 32'(sample_ready), 0);
  endtask

  task automatic tick();
    @(posedge clk_in);
    t++;
    model_edge();
    #1;
    if (t + 1 == push_edge) begin
      sample_valid = 1'b1; sample_l = push_l; sample_r = push_r;
    end else begin
      case (mode)
        2: begin sample_valid = 1'b1; sample_l = 16'($urandom); sample_r = 16'($urandom); end
        3: begin
             sample_valid = ($urandom_range(0, 15) == 0);
             sample_l = 16'($urandom); sample_r = 16'($urandom);
           end
        default: sample_valid = 1'b0;
      endcase
    end
    @(negedge clk_in);
    check_cycle();
  endtask

  // Monitor: rebuild 32-bit frames from bits sampled on BCLK rising edges.
  logic        bclk_prev, prev_lr, collecting;
  int          nbits;
  logic [31:0] acc;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      bclk_prev = 1'b0; prev_lr = 1'b1; collecting = 1'b0; nbits = 0; acc = '0;
    end else begin
      if (i2s_bclk && !bclk_prev) begin
        if (!i2s_lrclk && prev_lr) begin
          if (collecting && nbits == 31) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL frame_unexpected: got %0h expected none (t=%0d)", {acc[30:0], i2s_sdata}, t);
            end else begin
              checks--;
              chk("frame", {acc[30:0], i2s_sdata}, exp_q.pop_front());
            end
          end
          collecting = 1'b1; nbits = 0; acc = '0;
        end else if (collecting) begin
          acc = {acc[30:0], i2s_sdata};
          nbits++;
        end
        prev_lr = i2s_lrclk;
      end
      bclk_prev = i2s_bclk;
    end
  end

  initial begin
    rst_n_in = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
    mode = 0; push_edge = -1; push_l = '0; push_r = '0; t = 0;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("reset");
    rst_n_in = 1'b1;
    t = 0;

    push_edge = 2; push_l = 16'hA5F0; push_r = 16'h0F5A;
    while (t < 10) tick();
    push_edge = 2 * FPER + BPER; push_l = 16'($urandom); push_r = 16'($urandom);
    while (t < 3 * FPER) tick();
    mode = 2;
    while (t < 7 * FPER) tick();
    mode = 3;
    while (t < RST_T) tick();

    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("async_reset");
    sample_valid = 1'b0; mode = 0; push_edge = -1;
    model_reset();
    repeat (3) @(negedge clk_in);
    check_reset_outputs("held_reset");
    rst_n_in = 1'b1;
    t = 0;

    push_edge = 3; push_l = 16'h8000; push_r = 16'h7FFF;
    while (t < FPER + HALF + 1) tick();
    chk("frames_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
